fmap_capture_mc: RTL
====================

# fmap_capture_mc

Multi-channel feature-map column writer. It is the parametrised successor of the single-channel 256-bit capture stage and sits between the convolution core's column outputs and the local result BRAM. Each accepted column carries `NUM_CH` channels of `PIX_H` pixels. The block registers the column, splits every channel into `BRAM_DW`-wide words and writes them one per cycle into per-channel address regions. It applies backpressure through a ready handshake and reports completion when the frame ends.

## Interface
Parameters:
- `DATA_WIDTH`, 16: bits per pixel.
- `PIX_H`, 24: pixels per column per channel.
- `PIX_W`, 24: columns per frame.
- `NUM_CH`, 4: channels per column.
- `BRAM_DW`, 256: BRAM word width. Must be a multiple of `DATA_WIDTH`.
- `ADDR_W`, 12: BRAM address width.
- `BASE_ADDR`, 0: address of channel 0, column 0, word 0.
- `CH_STRIDE`, `PIX_W*WPC`: address distance between channel regions.
- Derived values:
  - PPW = `BRAM_DW/DATA_WIDTH` (pixels per word, 16 at defaults).
  - WPC = ceil(`PIX_H`/PPW) (words per channel-column, 2 at defaults).

Ports (name, direction, width, meaning):
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: arms a new frame.
- `valid_col` in 1: column present on `data_col`.
- `col_ready` out 1: block can accept a column this cycle.
- `data_col` in `NUM_CH*PIX_H*DATA_WIDTH`: channel c, pixel p is at bits `[(c*PIX_H+p)*DATA_WIDTH +: DATA_WIDTH]`.
- `conv_done` in 1: the producer has finished the frame.
- `bram_addr` out `ADDR_W`: write address.
- `bram_wrdata` out `BRAM_DW`: write data.
- `bram_we` out 1: write enable.
- `busy` out 1: the block is in ARMED or WRITE.
- `col_count` out `$clog2(PIX_W+1)`: number of columns accepted in the current frame.
- `overflow_err` out 1: sticky error flag.
- `write_done` out 1: the frame is fully written. Held high.

## Operation
FSM states: IDLE, ARMED, WRITE, DONE.

- **Reset values:** state IDLE. `col_ready`, `bram_we`, `busy`, `write_done` and `overflow_err` are 0. `bram_addr`, `bram_wrdata` and `col_count` are 0.
- **IDLE or DONE:**
  - `start` → ARMED. The same edge clears `col_count`, `write_done`, `overflow_err` and `done_pending`.
  - `start` in ARMED or WRITE is ignored.
- **ARMED:** `col_ready = 1` (combinational from state).
  - valid&ready: latch `data_col` into the column buffer, increment `col_count`, → WRITE.
  - Otherwise, if `done_pending` or `col_count == PIX_W` → DONE.
- **WRITE:** iterate channel c = 0..`NUM_CH`-1 (outer loop) and word w = 0..WPC-1 (inner loop). This is one registered BRAM write per cycle.
  - Address = `BASE_ADDR + c*CH_STRIDE + x*WPC + w`, where x = column index (`col_count`-1). Arithmetic is done at `ADDR_W` bits and wraps modulo 2^`ADDR_W`.
  - Data: lane l of word w holds pixel p = w*PPW + l at bits `[l*DATA_WIDTH +: DATA_WIDTH]`. Lanes with p ≥ `PIX_H` are zero.
  - After the final word → ARMED, or → DONE if `col_count == PIX_W` or `done_pending`.
- **`done_pending`:** set when `conv_done` is seen in ARMED or WRITE. It is sticky until `start`.
  - If `conv_done` arrives in the same cycle as an accepted column, the column is still written completely before DONE.
- **DONE:** `write_done = 1` and is held. `busy = 0`.
- **`overflow_err` is set** by either of:
  - `valid_col` while `col_ready = 0` and state is ARMED/WRITE. The column is dropped.
  - `valid_col` in ARMED when `col_count == PIX_W`. The column is dropped and no write occurs.
- `valid_col` in IDLE or DONE is ignored and does not set the error.
- **`rst` mid-frame:** all state clears immediately. A partial column is abandoned and there is no further `bram_we`.

## Timing
- Column accepted at edge N: first `bram_we` is visible after edge N+1. There are `NUM_CH*WPC` consecutive write cycles with no gaps.
- `col_ready` returns high the cycle after the last write. Sustained throughput is one column per `NUM_CH*WPC+1` cycles (9 at defaults).
- `bram_addr`, `bram_wrdata` and `bram_we` are registered and change together. `bram_we` is never high outside WRITE.
- `write_done` rises one cycle after the last write, or one cycle after `conv_done` in ARMED with no write outstanding.
- The column buffer is stable during WRITE. `data_col` may change freely after acceptance.

## Test plan
- **Single column:** reset, `start`, then one column at defaults with channel c pixel p = {c[3:0], p[11:0]}, then `conv_done`.
  - Expect 8 writes at addresses 0x000, 0x001, 0x030, 0x031, 0x060, 0x061, 0x090, 0x091.
  - Word 1 of each channel has its upper 128 bits zero.
  - `write_done` is high 1 cycle after the last write.
- **Full frame:** 24 back-to-back columns with `valid_col` held high.
  - Expect acceptance every 9 cycles and 192 writes; the last write is at 0x0BF.
  - DONE is reached without `conv_done`, and `col_count = 24`.
- **Backpressure violation:** `valid_col` pulsed during WRITE.
  - Expect `overflow_err = 1`, no extra writes, and `col_count` unchanged.
- **Simultaneous end:** `conv_done` and `valid_col` in the same ARMED cycle at column 5.
  - Expect all 8 writes for x = 5, then DONE, with `col_count = 6`.
- **Reset mid-write:** assert `rst` on the 3rd write cycle.
  - Expect all outputs at reset values immediately and no `bram_we` afterwards.
  - A following `start` gives a clean frame from address 0x000.
- **Non-default parameters:** `DATA_WIDTH = 8`, `PIX_H = 32`, `BRAM_DW = 256`, `NUM_CH = 1`.
  - Expect 1 write per column with every lane filled, and `col_ready` returning every 2 cycles.

Source files
------------

// File: rtl/fmap_capture_mc_if.sv
// Column-in / BRAM-out bundle for fmap_capture_mc.
// Latency: none (wires only).
// Backpressure: col_ready qualifies valid_col; the BRAM side cannot stall.
//   master: column producer / BRAM sink side (drives valid_col, data_col)
//   slave : capture block side (drives col_ready and the BRAM write port)
interface fmap_capture_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int PIX_H      = 24,
    parameter int NUM_CH     = 4,
    parameter int BRAM_DW    = 256,
    parameter int ADDR_W     = 12
);
    logic                                valid_col;
    logic                                col_ready;
    logic [NUM_CH*PIX_H*DATA_WIDTH-1:0]  data_col;
    logic [ADDR_W-1:0]                   bram_addr;
    logic [BRAM_DW-1:0]                  bram_wrdata;
    logic                                bram_we;

    modport master (
        output valid_col, data_col,
        input  col_ready, bram_addr, bram_wrdata, bram_we
    );

    modport slave (
        input  valid_col, data_col,
        output col_ready, bram_addr, bram_wrdata, bram_we
    );
endinterface

// File: rtl/fmap_capture_mc.sv
// Multi-channel feature-map column writer: buffers one column, writes NUM_CH*WPC BRAM words.
// Latency: first bram_we one cycle after acceptance, then one word per cycle with no gaps.
// Backpressure: col_ready only in ARMED; valid_col while not ready drops the column and sets overflow_err.
// Ports: clk/rst (async active-high); start arms a frame; conv_done ends it;
//        bus (slave) carries the column handshake and BRAM write port;
//        busy/col_count/overflow_err/write_done report frame status.
module fmap_capture_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int PIX_H      = 24,
    parameter int PIX_W      = 24,
    parameter int NUM_CH     = 4,
    parameter int BRAM_DW    = 256,
    parameter int ADDR_W     = 12,
    parameter int BASE_ADDR  = 0,
    parameter int CH_STRIDE  = PIX_W * ((PIX_H + (BRAM_DW / DATA_WIDTH) - 1) / (BRAM_DW / DATA_WIDTH))
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         conv_done,
    fmap_capture_mc_if.slave             bus,
    output logic                         busy,
    output logic [$clog2(PIX_W+1)-1:0]   col_count,
    output logic                         overflow_err,
    output logic                         write_done
);
    localparam int PPW      = BRAM_DW / DATA_WIDTH;
    localparam int WPC      = (PIX_H + PPW - 1) / PPW;
    localparam int CH_BITS  = PIX_H * DATA_WIDTH;
    localparam int COL_BITS = NUM_CH * CH_BITS;
    localparam int PAD_BITS = WPC * BRAM_DW;
    localparam int CNT_W    = $clog2(PIX_W + 1);
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WD_W     = (WPC > 1) ? $clog2(WPC) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ARMED,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                state_q,   state_d;
    logic [COL_BITS-1:0]   col_buf_q, col_buf_d;
    logic [CNT_W-1:0]      count_q,   count_d;
    logic [CH_W-1:0]       ch_q,      ch_d;
    logic [WD_W-1:0]       wd_q,      wd_d;
    logic                  pend_q,    pend_d;
    logic                  ovf_q,     ovf_d;
    logic                  wdone_q,   wdone_d;
    logic                  we_q,      we_d;
    logic [ADDR_W-1:0]     addr_q,    addr_d;
    logic [BRAM_DW-1:0]    wrdata_q,  wrdata_d;

    logic                  col_full;
    logic                  accept;
    logic                  last_word;
    logic                  finish;
    logic [ADDR_W-1:0]     addr_calc;
    logic [PAD_BITS-1:0]   chan_pad;
    logic [BRAM_DW-1:0]    word_calc;

    // Word address and data for the (ch_q, wd_q) word of the buffered column.
    // Address math is ADDR_W wide so it wraps naturally; x = col_count - 1
    // because the count is bumped on acceptance. Zero-padding the channel
    // slice up to WPC whole words makes the tail lanes of the last word zero.
    always_comb begin
        addr_calc = ADDR_W'(BASE_ADDR)
                  + ADDR_W'(ch_q) * ADDR_W'(CH_STRIDE)
                  + (ADDR_W'(count_q) - ADDR_W'(1)) * ADDR_W'(WPC)
                  + ADDR_W'(wd_q);
        chan_pad  = PAD_BITS'(col_buf_q[int'(ch_q) * CH_BITS +: CH_BITS]);
        word_calc = chan_pad[int'(wd_q) * BRAM_DW +: BRAM_DW];
    end

    always_comb begin
        col_full  = (count_q == CNT_W'(PIX_W));
        accept    = (state_q == S_ARMED) && bus.valid_col && !col_full;
        last_word = (ch_q == CH_W'(NUM_CH - 1)) && (wd_q == WD_W'(WPC - 1));
        // conv_done in the current cycle counts too, so DONE is not delayed by a cycle.
        finish    = pend_q || conv_done || col_full;

        state_d   = state_q;
        col_buf_d = col_buf_q;
        count_d   = count_q;
        ch_d      = ch_q;
        wd_d      = wd_q;
        pend_d    = pend_q;
        ovf_d     = ovf_q;
        wdone_d   = wdone_q;
        we_d      = 1'b0;
        addr_d    = addr_q;
        wrdata_d  = wrdata_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_ARMED;
                    count_d = '0;
                    pend_d  = 1'b0;
                    ovf_d   = 1'b0;
                    wdone_d = 1'b0;
                end else if (state_q == S_DONE) begin
                    // Rises the cycle after DONE is entered, i.e. after the last write has landed.
                    wdone_d = 1'b1;
                end
            end
            S_ARMED: begin
                if (conv_done) pend_d = 1'b1;
                if (accept) begin
                    col_buf_d = bus.data_col;
                    count_d   = count_q + CNT_W'(1);
                    ch_d      = '0;
                    wd_d      = '0;
                    state_d   = S_WRITE;
                end else begin
                    // Not accepted while valid means the frame is already full.
                    if (bus.valid_col) ovf_d = 1'b1;
                    if (finish) state_d = S_DONE;
                end
            end
            S_WRITE: begin
                if (conv_done) pend_d = 1'b1;
                if (bus.valid_col) ovf_d = 1'b1;
                we_d     = 1'b1;
                addr_d   = addr_calc;
                wrdata_d = word_calc;
                if (wd_q == WD_W'(WPC - 1)) begin
                    wd_d = '0;
                    ch_d = last_word ? '0 : ch_q + CH_W'(1);
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
                if (last_word) state_d = finish ? S_DONE : S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            col_buf_q <= '0;
            count_q   <= '0;
            ch_q      <= '0;
            wd_q      <= '0;
            pend_q    <= 1'b0;
            ovf_q     <= 1'b0;
            wdone_q   <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wrdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            col_buf_q <= col_buf_d;
            count_q   <= count_d;
            ch_q      <= ch_d;
            wd_q      <= wd_d;
            pend_q    <= pend_d;
            ovf_q     <= ovf_d;
            wdone_q   <= wdone_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wrdata_q  <= wrdata_d;
        end
    end

    assign bus.col_ready   = (state_q == S_ARMED);
    assign bus.bram_we     = we_q;
    assign bus.bram_addr   = addr_q;
    assign bus.bram_wrdata = wrdata_q;
    assign busy            = (state_q == S_ARMED) || (state_q == S_WRITE);
    assign col_count       = count_q;
    assign overflow_err    = ovf_q;
    assign write_done      = wdone_q;
endmodule
